// File: rtl/final_pkg.sv
// -----------------------------------------------------------------------------
// final_pkg
// Shared definitions for the FINAL loader slice: datapath widths, the loader
// state encoding and a length-clamping helper.
// -----------------------------------------------------------------------------
package final_pkg;

  localparam int FINAL_RES_W    = 20;
  localparam int FINAL_ADDR_B_W = 6;
  localparam int FINAL_DATA_B_W = 32;
  localparam int FINAL_LEN_W    = 7;

  // Loader state encoding
  localparam logic [2:0] FINAL_ST_IDLE   = 3'd0;
  localparam logic [2:0] FINAL_ST_FILL   = 3'd1;
  localparam logic [2:0] FINAL_ST_FLUSH  = 3'd2;
  localparam logic [2:0] FINAL_ST_RUN    = 3'd3;
  localparam logic [2:0] FINAL_ST_REPORT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = FINAL_ST_IDLE,
    ST_FILL   = FINAL_ST_FILL,
    ST_FLUSH  = FINAL_ST_FLUSH,
    ST_RUN    = FINAL_ST_RUN,
    ST_REPORT = FINAL_ST_REPORT
  } final_state_e;

  // Limit a requested word count to the port-B depth.
  function automatic logic [FINAL_LEN_W-1:0] final_clamp_len(
    input logic [FINAL_LEN_W-1:0] len,
    input logic [FINAL_LEN_W-1:0] max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/final_byte_packer.sv
// -----------------------------------------------------------------------------
// final_byte_packer
// Packs a byte stream into 32-bit words, first byte in the LSB.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              synchronous clear of the byte position and partial word
//   en_i               packer may accept bytes this cycle
//   in_valid_i/in_data_i/in_ready_o   byte handshake
//   word_o             packed word; meaningful while word_stb_o is high
//   word_stb_o         high in the cycle the 4th byte of a word is accepted
// The strobe and word are combinational so the consumer can register them on
// the same edge that accepts the final byte.
// -----------------------------------------------------------------------------
module final_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic [31:0] word_o,
  output logic        word_stb_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] pack_q, pack_d;
  logic        accept_s;

  assign in_ready_o = en_i;
  assign accept_s   = en_i & in_valid_i;
  // Top byte comes straight from the input so the word is complete this cycle
  assign word_o     = {in_data_i, pack_q};
  assign word_stb_o = accept_s & (byte_cnt_q == 2'd3);

  // Next byte position and partial word
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    if (clr_i) begin
      byte_cnt_d = 2'd0;
      pack_d     = 24'd0;
    end else if (accept_s) begin
      case (byte_cnt_q)
        2'd0:    pack_d[7:0]   = in_data_i;
        2'd1:    pack_d[15:8]  = in_data_i;
        2'd2:    pack_d[23:16] = in_data_i;
        default: pack_d        = pack_q;
      endcase
      byte_cnt_d = byte_cnt_q + 2'd1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  // Packer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= 2'd0;
      pack_q     <= 24'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
    end
  end

endmodule

// File: rtl/final_loader.sv
// -----------------------------------------------------------------------------
// final_loader
// Loads a byte stream as 32-bit words into SRAM port B (address 0 upward),
// starts the FINAL core with Go_t, waits for Done_t and returns Result_t on a
// valid/ready result handshake.
// Parameters: MAX_WORDS (port-B depth, <= 64), TIMEOUT_CYC (RUN cycle limit).
// Ports:
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   start, len_words                load request (sampled in IDLE only)
//   in_valid, in_data, in_ready     byte input handshake
//   M_di32, M_Addr6, M_enb, M_web   registered port-B write interface
//   Go_t, Done_t, Result_t          core run control and result
//   res_valid, res_data, res_err, res_ready   result handshake
//   busy                            high whenever not IDLE
// Build option: define FINAL_LOADER_TIMEOUT_EN to abort RUN after TIMEOUT_CYC
// cycles without Done_t (result reported with res_err=1, res_data=0).
// -----------------------------------------------------------------------------
module final_loader
  import final_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      start,
  input  logic [FINAL_LEN_W-1:0]    len_words,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic [FINAL_DATA_B_W-1:0] M_di32,
  output logic [FINAL_ADDR_B_W-1:0] M_Addr6,
  output logic                      M_enb,
  output logic                      M_web,
  output logic                      Go_t,
  input  logic                      Done_t,
  input  logic [FINAL_RES_W-1:0]    Result_t,
  output logic                      res_valid,
  output logic [FINAL_RES_W-1:0]    res_data,
  output logic                      res_err,
  input  logic                      res_ready,
  output logic                      busy
);

  final_state_e              state_q, state_d;
  logic [FINAL_LEN_W-1:0]    n_q, n_d;
  logic [FINAL_LEN_W-1:0]    wcnt_q, wcnt_d;
  logic [FINAL_DATA_B_W-1:0] di_q, di_d;
  logic [FINAL_ADDR_B_W-1:0] addr_q, addr_d;
  logic                      enb_q, enb_d;
  logic                      go_q, go_d;
  logic                      rvalid_q, rvalid_d;
  logic [FINAL_RES_W-1:0]    rdata_q, rdata_d;
  logic                      rerr_q, rerr_d;

  logic                      clr_s;
  logic                      fill_s;
  logic [31:0]               word_s;
  logic                      word_stb_s;

`ifdef FINAL_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYC == 32'd0);
`endif

  assign fill_s = (state_q == ST_FILL);

  final_byte_packer u_packer (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .clr_i      (clr_s),
    .en_i       (fill_s),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .word_o     (word_s),
    .word_stb_o (word_stb_s)
  );

  assign M_di32    = di_q;
  assign M_Addr6   = addr_q;
  assign M_enb     = enb_q;
  assign M_web     = enb_q;  // every port-B access from this block is a write
  assign Go_t      = go_q;
  assign res_valid = rvalid_q;
  assign res_data  = rdata_q;
  assign res_err   = rerr_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wcnt_d   = wcnt_q;
    di_d     = di_q;
    addr_d   = addr_q;
    enb_d    = 1'b0;
    go_d     = go_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    clr_s    = 1'b0;
`ifdef FINAL_LOADER_TIMEOUT_EN
    to_d     = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d    = final_clamp_len(len_words, FINAL_LEN_W'(MAX_WORDS));
          wcnt_d = 7'd0;
          clr_s  = 1'b1;
`ifdef FINAL_LOADER_TIMEOUT_EN
          to_d   = '0;
`endif
          if (n_d == 7'd0) begin
            state_d = ST_RUN;
            go_d    = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (word_stb_s) begin
          enb_d  = 1'b1;
          di_d   = word_s;
          addr_d = wcnt_q[FINAL_ADDR_B_W-1:0];
          wcnt_d = wcnt_q + 7'd1;
          // The last word's write lands in the FLUSH cycle
          if (wcnt_q == (n_q - 7'd1)) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
        go_d    = 1'b1;
`ifdef FINAL_LOADER_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      ST_RUN: begin
        // Done_t is checked first so it wins over a simultaneous expiry
        if (Done_t) begin
          rdata_d  = Result_t;
          rerr_d   = 1'b0;
          go_d     = 1'b0;
          rvalid_d = 1'b1;
          state_d  = ST_REPORT;
        end else begin
`ifdef FINAL_LOADER_TIMEOUT_EN
          if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
            rdata_d  = '0;
            rerr_d   = 1'b1;
            go_d     = 1'b0;
            rvalid_d = 1'b1;
            state_d  = ST_REPORT;
          end else begin
            to_d    = to_q + TO_W'(1);
            state_d = ST_RUN;
          end
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_REPORT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        go_d     = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      n_q      <= 7'd0;
      wcnt_q   <= 7'd0;
      di_q     <= 32'd0;
      addr_q   <= 6'd0;
      enb_q    <= 1'b0;
      go_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 20'd0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wcnt_q   <= wcnt_d;
      di_q     <= di_d;
      addr_q   <= addr_d;
      enb_q    <= enb_d;
      go_q     <= go_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

`ifdef FINAL_LOADER_TIMEOUT_EN
  // RUN cycle counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

endmodule
